seg_scan: RTL and testbench
===========================

# seg_scan

Time-multiplexed digit scanner for a common-cathode multi-digit seven-segment display. It holds a DIGITS-nibble value and presents one nibble at a time on `hex` for the downstream hex-to-segment decoder. It drives the matching active-low digit enable with a programmable dead-time against ghosting. New values are double-buffered and only take effect at frame boundaries, so a displayed number never tears.

## Interface
- `DIGITS`, default 4: number of digits scanned; legal range 1..8.
- `PRESCALE`, default 50000: clock cycles per digit slot; must be at least 2.
- `DEAD`, default 16: cycles at slot start with all digits off; 0 <= DEAD < PRESCALE.
- `clk`, in, 1: sole clock; all state on its rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `load`, in, 1: single-cycle strobe; capture `data_in`.
- `data_in`, in, 4*DIGITS: value to display; nibble i belongs to digit i, digit 0 is least significant.
- `hex`, out, 4: nibble of the digit currently scanned; feeds the segment decoder.
- `dig_n`, out, DIGITS: active-low one-hot digit enable; all ones means blank.
- `frame`, out, 1: one-cycle pulse at the start of each scan frame.

## Operation
- Registers:
  - `cnt`: slot cycle counter, 0..PRESCALE-1, $clog2(PRESCALE) bits.
  - `idx`: digit index, 0..DIGITS-1.
  - `pending`: shadow value register.
  - `display`: active value register.
- `cnt` increments every cycle.
  - At PRESCALE-1 it wraps to 0 and `idx` advances.
  - `idx` wraps from DIGITS-1 to 0.
- Frame boundary: the edge where `cnt`==PRESCALE-1 and `idx`==DIGITS-1. At that edge:
  - `display` <= `pending`;
  - `frame` <= 1 for exactly one cycle.
- `load`=1 writes `data_in` into `pending` at the same edge.
- If `load` coincides with a frame boundary, `data_in` also goes straight into `display`. The new value is used in the frame that is starting.
- Several loads within one frame: the last one wins.
- `load` has no effect on `cnt` or `idx`.
- Digit drive, per slot:
  - `hex` = `display` nibble `idx` for the whole slot.
  - `dig_n` = all ones while `cnt` < DEAD.
  - Otherwise `dig_n` has bit `idx` low and all other bits high.
- Scan order is digit 0 first, then upward: 1110, 1101, 1011, 0111 for DIGITS=4.

## Timing
- Reset (asynchronous, takes effect immediately), all registers cleared:
  - `cnt`=0, `idx`=0, `pending`=0, `display`=0;
  - `hex`=0, `dig_n`=all ones, `frame`=0.
- `hex`, `dig_n` and `frame` are registered and glitch-free. They reflect the `cnt`/`idx`/`display` state with 1-cycle latency.
- First slot after reset release: `dig_n` stays all ones for DEAD+1 cycles, then enables digit 0 for PRESCALE-DEAD cycles.
- Slot length is PRESCALE cycles. Frame period is DIGITS*PRESCALE cycles.
- `frame` is high in the same cycle that `hex` first shows digit 0 of the new `display`.
- Load latency to visible display:
  - at most DIGITS*PRESCALE+1 cycles;
  - exactly 1 cycle when the load coincides with a frame boundary.
- Reset mid-scan: outputs and state return to reset values at once, and `pending` is discarded. The scan restarts at slot 0.
- DEAD=0: no blank cycles; the digit is enabled for the full slot.

## Configuration
- `SEG_SCAN_LZB_EN` defined: leading-zero blanking.
  - Zero nibbles of `display`, counted from digit DIGITS-1 down to the first nonzero nibble, keep `dig_n` all ones for their entire slot.
  - Digit 0 is never blanked.
  - Slot timing, `hex` and `frame` are unchanged.
- `SEG_SCAN_LZB_EN` undefined: every digit is enabled in its slot regardless of value.

## Test plan
All scenarios use DIGITS=4, PRESCALE=8, DEAD=2.
- Reset held low:
  - during reset: `hex`=0, `dig_n`=1111, `frame`=0;
  - after release: 3 cycles of 1111, then 1110 for 6 cycles, then 1111 twice, then 1101.
- Slot sequencing, checked over one 32-cycle frame:
  - `dig_n` sequence 1110, 1101, 1011, 0111, each active 6 cycles after 2 blank cycles;
  - one `frame` pulse every 32 cycles.
- Load 16'h1234 during slot 2:
  - current frame still shows the old value;
  - after the next `frame` pulse, slots give `hex` 4, 3, 2, 1.
- Load 16'hBEEF on the exact frame-boundary edge, with an earlier pending load of 16'h1111 in the same frame: the starting frame shows F, E, E, B, and 16'h1111 is never displayed.
- Leading-zero blanking with `SEG_SCAN_LZB_EN`:
  - value 16'h0070: slots 3 and 2 stay 1111, slot 1 enables with `hex`=7, slot 0 enables with `hex`=0;
  - value 16'h0000: only digit 0 is lit;
  - without the macro: all four digits are lit for both values.
- Reset pulse during slot 2 with a pending unapplied load:
  - `dig_n`=1111 and `hex`=0 immediately;
  - after release, scan restarts at digit 0 displaying 0.

Source files
------------

// File: rtl/seg_scan.sv
// seg_scan: time-multiplexed scanner for a common-cathode multi-digit
// seven-segment display. Presents one nibble per slot on hex together with an
// active-low one-hot digit enable, inserting DEAD blank cycles at slot start.
// New values are staged in a shadow register and committed only at frame
// boundaries so a displayed number never tears.
// Optional feature: define SEG_SCAN_LZB_EN for leading-zero blanking.
module seg_scan #(
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned PRESCALE = 50000,
  parameter int unsigned DEAD     = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   data_in,
  output logic [3:0]            hex,
  output logic [DIGITS-1:0]     dig_n,
  output logic                  frame
);

  localparam int unsigned CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned DW = 4 * DIGITS;

  logic [CW-1:0]     r_cnt;
  logic [IW-1:0]     r_idx;
  logic [DW-1:0]     r_pending;
  logic [DW-1:0]     r_display;
  logic [3:0]        r_hex;
  logic [DIGITS-1:0] r_dig_n;
  logic              r_bnd;
  logic              r_frame;

  logic              w_slot_end;
  logic              w_frame_end;
  logic              w_dead;
  logic              w_blank;
  logic [3:0]        w_hex;
  logic [DIGITS-1:0] w_onehot_n;

  assign w_slot_end  = (r_cnt == CW'(PRESCALE - 1));
  assign w_frame_end = w_slot_end && (r_idx == IW'(DIGITS - 1));

  // Dead-time window at the start of every slot (none when DEAD is zero)
  generate
    if (DEAD == 0) begin : g_no_dead
      assign w_dead = 1'b0;
    end else begin : g_dead
      assign w_dead = (r_cnt < CW'(DEAD));
    end
  endgenerate

  // Nibble select and active-low one-hot enable for the current digit
  always_comb begin
    w_hex      = 4'h0;
    w_onehot_n = '1;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (r_idx == IW'(i)) begin
        w_hex         = r_display[4*i +: 4];
        w_onehot_n[i] = 1'b0;
      end
    end
  end

`ifdef SEG_SCAN_LZB_EN
  // Blank a digit when it and every more significant nibble are zero; digit 0 stays lit
  always_comb begin
    logic v_run;
    v_run   = 1'b1;
    w_blank = 1'b0;
    for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
      v_run = v_run && (r_display[4*i +: 4] == 4'h0);
      if (r_idx == IW'(i)) begin
        w_blank = v_run;
      end
    end
  end
`else
  assign w_blank = 1'b0;
`endif

  // Slot cycle counter and digit index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else if (w_slot_end) begin
      r_cnt <= '0;
      r_idx <= w_frame_end ? '0 : r_idx + IW'(1);
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  // Shadow capture on load; commit to display at the frame boundary (a coincident load wins)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= '0;
      r_display <= '0;
    end else begin
      if (load) begin
        r_pending <= data_in;
      end
      if (w_frame_end) begin
        r_display <= load ? data_in : r_pending;
      end
    end
  end

  // Registered outputs, one cycle behind the scan state; frame aligns with new digit 0 on hex
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hex   <= 4'h0;
      r_dig_n <= '1;
      r_bnd   <= 1'b0;
      r_frame <= 1'b0;
    end else begin
      r_hex   <= w_hex;
      r_dig_n <= (w_dead || w_blank) ? '1 : w_onehot_n;
      r_bnd   <= w_frame_end;
      r_frame <= r_bnd;
    end
  end

  assign hex   = r_hex;
  assign dig_n = r_dig_n;
  assign frame = r_frame;

endmodule

// File: tb/tb_seg_scan.sv
// Self-checking bench for seg_scan (DIGITS=4, PRESCALE=8, DEAD=2).
// Expected outputs come from an arithmetic model indexed by the number of
// clock edges since reset release.
module tb_seg_scan;

  localparam int unsigned D  = 4;
  localparam int unsigned P  = 8;
  localparam int unsigned DT = 2;
  localparam int unsigned DP = D * P;

  logic        clk;
  logic        rst_n;
  logic        load;
  logic [15:0] data_in;
  logic [3:0]  hex;
  logic [3:0]  dig_n;
  logic        frame;

  int          checks;
  int          errors;
  int          k;
  logic [15:0] m_pend;
  logic [15:0] m_disp;

  seg_scan #(.DIGITS(D), .PRESCALE(P), .DEAD(DT)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load),
    .data_in (data_in),
    .hex     (hex),
    .dig_n   (dig_n),
    .frame   (frame)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h (k=%0d)", tag, obs, exp, k);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b (k=%0d)", tag, obs, exp, k);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock with optional load; outputs after the edge reflect scan position k
  task automatic step(input logic ld, input logic [15:0] d);
    int         cnt;
    int         idx;
    logic       blank;
    logic [3:0] e_hex;
    logic [3:0] e_dig;
    logic       e_frame;
    load    = ld;
    data_in = d;
    @(posedge clk);
    cnt     = int'(k % P);
    idx     = int'((k / P) % D);
    e_hex   = 4'(m_disp >> (4 * idx));
    e_frame = (k > 0) && (k % DP == 0);
    blank   = (cnt < int'(DT));
`ifdef SEG_SCAN_LZB_EN
    if (idx != 0 && (m_disp >> (4 * idx)) == 16'h0) blank = 1'b1;
`endif
    e_dig = blank ? 4'hF : ~(4'(1) << idx);
    if (k % DP == DP - 1) m_disp = ld ? d : m_pend;
    if (ld) m_pend = d;
    k++;
    #1;
    load = 1'b0;
    chk4("hex", hex, e_hex);
    chk4("dig_n", dig_n, e_dig);
    chk1("frame", frame, e_frame);
  endtask

  task automatic run(input int n);
    repeat (n) step(1'b0, 16'h0);
  endtask

  task automatic run_to(input int m);
    while (k % DP != m) step(1'b0, 16'h0);
  endtask

  task automatic wait_frame();
    int n;
    n = 0;
    while (frame !== 1'b1 && n < 100) begin
      step(1'b0, 16'h0);
      n++;
    end
    chk1("frame_seen", frame, 1'b1);
  endtask

  task automatic model_reset();
    k      = 0;
    m_pend = 16'h0;
    m_disp = 16'h0;
  endtask

  // Checks the four slot nibbles of the frame that has just started
  task automatic check_frame_hex(input logic [15:0] v);
    for (int s = 0; s < int'(D); s++) begin
      chk4("slot_hex", hex, 4'(v >> (4 * s)));
      run(int'(P));
    end
  endtask

  initial begin
    logic [3:0] seq [11];
    int         nf;
    seq = '{4'hF, 4'hF, 4'hE, 4'hE, 4'hE, 4'hE, 4'hE, 4'hE, 4'hF, 4'hF, 4'hD};
    checks  = 0;
    errors  = 0;
    rst_n   = 1'b0;
    load    = 1'b1;
    data_in = 16'hFFFF;
    model_reset();

    // Held in reset, loads ignored
    repeat (3) begin
      @(posedge clk);
      #1;
      chk4("rst_hex", hex, 4'h0);
      chk4("rst_dig_n", dig_n, 4'hF);
      chk1("rst_frame", frame, 1'b0);
    end
    load    = 1'b0;
    data_in = 16'h0;
    rst_n   = 1'b1;
    chk4("rel_dig_n", dig_n, 4'hF);

    // First slots after release: 3 blank, 6 x 1110, 2 blank, 1101
    for (int i = 0; i < 11; i++) begin
      step(1'b0, 16'h0);
      chk4("rel_seq", dig_n, seq[i]);
    end

    // One frame pulse per 32 cycles
    run_to(0);
    nf = 0;
    repeat (2 * DP) begin
      step(1'b0, 16'h0);
      nf += int'(frame);
    end
    chki("frame_count", nf, 2);

    // Load during slot 2: old value until the next frame
    run_to(int'(2 * P + 3));
    step(1'b1, 16'h1234);
    wait_frame();
    check_frame_hex(16'h1234);

    // Earlier load overridden by a load on the boundary edge
    run_to(5);
    step(1'b1, 16'h1111);
    run_to(int'(DP - 1));
    step(1'b1, 16'hBEEF);
    wait_frame();
    check_frame_hex(16'hBEEF);

    // Leading-zero patterns
    step(1'b1, 16'h0070);
    wait_frame();
    check_frame_hex(16'h0070);
    step(1'b1, 16'h0000);
    wait_frame();
    check_frame_hex(16'h0000);
    step(1'b1, 16'h0500);
    wait_frame();
    run(int'(DP));

    // Random loads
    repeat (400) step($urandom_range(9, 0) == 0, 16'($urandom));

    // Reset mid-scan with an unapplied pending load
    run_to(3);
    step(1'b1, 16'hA5A5);
    run_to(int'(2 * P + 3));
    rst_n = 1'b0;
    #1;
    chk4("mid_rst_hex", hex, 4'h0);
    chk4("mid_rst_dig_n", dig_n, 4'hF);
    chk1("mid_rst_frame", frame, 1'b0);
    model_reset();
    @(posedge clk);
    #1;
    chk4("mid_rst_hold_dig_n", dig_n, 4'hF);
    rst_n = 1'b1;
    for (int i = 0; i < 11; i++) begin
      step(1'b0, 16'h0);
      chk4("restart_seq", dig_n, seq[i]);
    end
    run(int'(2 * DP));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
